// File: rtl/fifo_stream_reader.sv
// Read side of a registered-output SFIFO turned into a ready/valid stream through a 2-entry skid buffer.
// Optional word counter port enabled by defining FIFO_STREAM_READER_COUNT_EN.
module fifo_stream_reader #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] FIFORdData,
    input  logic             FIFOEmpty,
    output logic             FIFORdReq,
    output logic [Width-1:0] OutData,
    output logic             OutValid,
    input  logic             OutReady
`ifdef FIFO_STREAM_READER_COUNT_EN
    ,
    output logic [15:0]      WordCount
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t             occ_q, occ_d;
    logic             in_flight_q, in_flight_d;
    logic             run_q, run_d;
    logic [Width-1:0] head_q, head_d;
    logic [Width-1:0] tail_q, tail_d;
    logic             pop;
    logic [2:0]       level;
    logic [2:0]       limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q       <= EMPTY;
            in_flight_q <= 1'b0;
            run_q       <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            occ_q       <= occ_d;
            in_flight_q <= in_flight_d;
            run_q       <= run_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

    // run_q holds off requests until the first edge after reset release.
    always_comb begin
        occ_d       = occ_q;
        head_d      = head_q;
        tail_d      = tail_q;
        run_d       = 1'b1;
        pop         = (occ_q != EMPTY) && OutReady;
        level       = {1'b0, occ_q} + {2'b00, in_flight_q};
        limit       = 3'd2 + {2'b00, pop};
        FIFORdReq   = run_q && !FIFOEmpty && (level < limit);
        in_flight_d = FIFORdReq;

        unique case (occ_q)
            EMPTY: begin
                if (in_flight_q) begin
                    head_d = FIFORdData;
                    occ_d  = ONE;
                end
            end
            ONE: begin
                unique case ({in_flight_q, pop})
                    2'b10: begin
                        tail_d = FIFORdData;
                        occ_d  = TWO;
                    end
                    2'b01: occ_d = EMPTY;
                    2'b11: head_d = FIFORdData;
                    default: occ_d = ONE;
                endcase
            end
            TWO: begin
                // Capture without pop cannot happen here: the request was gated on free space.
                if (pop) begin
                    head_d = tail_q;
                    if (in_flight_q) begin
                        tail_d = FIFORdData;
                    end else begin
                        occ_d = ONE;
                    end
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    assign OutValid = (occ_q != EMPTY);
    assign OutData  = head_q;

`ifdef FIFO_STREAM_READER_COUNT_EN
    logic [15:0] count_q, count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q + {15'd0, pop};
    end

    assign WordCount = count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small registered-read SFIFO model upstream.
module tb_fifo_stream_reader;

    logic       clk;
    logic       reset;
    logic [7:0] FIFORdData;
    logic       FIFOEmpty;
    logic       FIFORdReq;
    logic [7:0] OutData;
    logic       OutValid;
    logic       OutReady;
`ifdef FIFO_STREAM_READER_COUNT_EN
    logic [15:0] WordCount;
`endif

    fifo_stream_reader #(.Width(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .FIFORdData(FIFORdData),
        .FIFOEmpty (FIFOEmpty),
        .FIFORdReq (FIFORdReq),
        .OutData   (OutData),
        .OutValid  (OutValid),
        .OutReady  (OutReady)
`ifdef FIFO_STREAM_READER_COUNT_EN
        ,
        .WordCount (WordCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream SFIFO model: words written by the stimulus, read data registered one cycle after the request.
    logic [7:0] mem [0:15];
    int         wr_n = 0;
    int         rd_n = 0;
    logic       endless = 1'b0;

    assign FIFOEmpty = !endless && (rd_n >= wr_n);

    initial FIFORdData = 8'h00;
    always @(posedge clk) begin
        if (FIFORdReq) begin
            FIFORdData <= mem[rd_n % 16];
            rd_n       <= rd_n + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr_n % 16] = w;
        wr_n++;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int r0;
    int pops;
    int guard;

    initial begin
        reset    = 1'b1;
        OutReady = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_valid", OutValid, 0);
        check_eq("rst_rdreq", FIFORdReq, 0);
        check_eq("rst_data", OutData, 0);
`ifdef FIFO_STREAM_READER_COUNT_EN
        check_eq("rst_count", WordCount, 0);
`endif
        reset = 1'b0;
        #1;
        check_eq("idle_rdreq", FIFORdReq, 0);
        step();
        step();

        // Three words streamed with OutReady held high
        OutReady = 1'b1;
        push(8'h24); push(8'h81); push(8'h09);
        #1;
        check_eq("lat_rdreq", FIFORdReq, 1);
        step();
        check_eq("lat_valid1", OutValid, 0);
        step();
        check_eq("seq0_valid", OutValid, 1);
        check_eq("seq0_data", OutData, 8'h24);
        step();
        check_eq("seq1_valid", OutValid, 1);
        check_eq("seq1_data", OutData, 8'h81);
        step();
        check_eq("seq2_valid", OutValid, 1);
        check_eq("seq2_data", OutData, 8'h09);
        step();
        check_eq("seq_end_valid", OutValid, 0);

        // Backpressure: only two reads until space frees up
        OutReady = 1'b0;
        r0 = rd_n;
        push(8'hA1); push(8'hB2); push(8'hC3);
        repeat (6) step();
        check_eq("bp_reads", rd_n - r0, 2);
        check_eq("bp_rdreq", FIFORdReq, 0);
        check_eq("bp_valid", OutValid, 1);
        check_eq("bp_data", OutData, 8'hA1);
        step();
        check_eq("bp_hold", OutData, 8'hA1);

        // One-cycle ready pulse refills in the same cycle
        OutReady = 1'b1;
        #1;
        check_eq("pulse_rdreq", FIFORdReq, 1);
        step();
        OutReady = 1'b0;
        check_eq("pulse_data", OutData, 8'hB2);
        step();
        check_eq("pulse_reads", rd_n - r0, 3);
        check_eq("pulse_hold", OutData, 8'hB2);
        check_eq("pulse_valid", OutValid, 1);
        OutReady = 1'b1;
        step();
        check_eq("drain_data", OutData, 8'hC3);
        step();
        check_eq("drain_valid", OutValid, 0);

        // Single word then empty
        r0 = rd_n;
        push(8'h5A);
        step();
        step();
        check_eq("one_valid", OutValid, 1);
        check_eq("one_data", OutData, 8'h5A);
        step();
        check_eq("one_drop", OutValid, 0);
        step();
        step();
        check_eq("one_nocap", OutValid, 0);
        check_eq("one_reads", rd_n - r0, 1);

        // Reset mid-stream with two words buffered
        OutReady = 1'b0;
        push(8'h11); push(8'h22); push(8'h33);
        repeat (4) step();
        check_eq("mid_valid", OutValid, 1);
        check_eq("mid_data", OutData, 8'h11);
        #1;
        reset = 1'b1;
        #1;
        check_eq("mrst_valid", OutValid, 0);
        check_eq("mrst_rdreq", FIFORdReq, 0);
        check_eq("mrst_data", OutData, 0);
`ifdef FIFO_STREAM_READER_COUNT_EN
        check_eq("mrst_count", WordCount, 0);
`endif
        step();
        reset = 1'b0;
        #1;
        check_eq("rel_rdreq", FIFORdReq, 0);
        step();
        check_eq("post_rdreq", FIFORdReq, 1);
        OutReady = 1'b1;
        step();
        step();
        check_eq("post_valid", OutValid, 1);
        check_eq("post_data", OutData, 8'h33);
        step();
        check_eq("post_end", OutValid, 0);

`ifdef FIFO_STREAM_READER_COUNT_EN
        // Counter wrap: 65537 pops leave WordCount at 1
        reset = 1'b1;
        step();
        reset = 1'b0;
        endless = 1'b1;
        pops  = 0;
        guard = 0;
        while (pops < 65537 && guard < 70000) begin
            if (OutValid) pops++;
            step();
            guard++;
        end
        OutReady = 1'b0;
        endless  = 1'b0;
        check_eq("wrap_guard", guard < 70000, 1);
        check_eq("wrap_count", WordCount, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter Width, default 8, data word width in bits; legal range 1..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port FIFORdData  input  Width  read data from the upstream SFIFO; registered, valid the cycle after an accepted read request.
REQ-005 SHALL have port FIFOEmpty  input  1  upstream SFIFO empty flag.
REQ-006 SHALL have port FIFORdReq  output  1  read request to the upstream SFIFO; one word per high cycle.
REQ-007 SHALL have port OutData  output  Width  downstream stream data.
REQ-008 SHALL have port OutValid  output  1  OutData holds a valid word.
REQ-009 SHALL have port OutReady  input  1  downstream accepts the word this cycle.
REQ-010 SHALL have port WordCount  output  16  words delivered downstream; present only when the macro is defined (REQ-029).

Function
REQ-011 SHALL hold an internal 2-entry ordered buffer with occupancy states EMPTY (0), ONE (1) and TWO (2).
REQ-012 SHALL track a 1-bit in-flight flag, set the cycle after FIFORdReq is high and clear otherwise.
REQ-013 SHALL define pop = OutValid AND OutReady.
REQ-014 SHALL assert FIFORdReq combinationally iff FIFOEmpty = 0 AND (occupancy + in-flight - pop) < 2.
REQ-015 SHALL write FIFORdData into the buffer tail on every cycle where the in-flight flag is 1.
REQ-016 SHALL drive OutValid = 1 iff occupancy is not EMPTY; OutData SHALL be the buffer head.
REQ-017 SHALL apply these transitions: capture without pop raises occupancy by 1; pop without capture lowers it by 1; capture with pop leaves it unchanged, with the head advanced.
REQ-018 SHALL never overflow: capture while in TWO without a same-cycle pop is unreachable by construction (REQ-014).
REQ-019 SHALL preserve upstream word order exactly; no word dropped or duplicated.
REQ-020 SHALL keep OutData and OutValid stable while OutValid = 1 and OutReady = 0.
REQ-021 SHALL sustain one word per cycle when FIFOEmpty = 0 and OutReady = 1 continuously, after an initial latency of 2 cycles from FIFOEmpty falling to OutValid rising.
REQ-022 SHALL ignore FIFORdData whenever the in-flight flag is 0.
REQ-023 SHALL be latency-transparent to OutReady: a high OutReady with OutValid = 0 has no effect.

Reset
REQ-024 SHALL, while reset = 1, force occupancy to EMPTY, in-flight to 0, OutValid to 0, FIFORdReq to 0 and WordCount to 0.
REQ-025 SHALL reset OutData to all zeros.
REQ-026 SHALL discard any buffered or in-flight word on reset mid-operation; the first read after release follows REQ-014.
REQ-027 SHALL not issue FIFORdReq in the cycle reset deasserts if the first rising edge has not yet occurred.

Configuration
REQ-028 SHALL use macro FIFO_STREAM_READER_COUNT_EN.
REQ-029 SHALL, with the macro defined, include WordCount, which increments by 1 on each pop, wraps from 65535 to 0 and resets to 0.
REQ-030 SHALL, with the macro undefined, omit the WordCount port and its counter logic; all other behaviour is unchanged.

Verification
REQ-031 SHALL cover this case: reset asserted mid-stream with 2 words buffered -> OutValid = 0 and FIFORdReq = 0 immediately; WordCount = 0.
REQ-032 SHALL cover this case: upstream holds 0x24, 0x81, 0x09 and OutReady is held at 1 -> OutData sequence 0x24, 0x81, 0x09 on 3 consecutive cycles; first OutValid 2 cycles after FIFOEmpty falls.
REQ-033 SHALL cover this case: OutReady = 0 with upstream non-empty -> exactly 2 reads issued, FIFORdReq then stays 0 and OutData holds the first word.
REQ-034 SHALL cover this case: from REQ-033, OutReady pulsed for 1 cycle -> the single pop triggers one new FIFORdReq in the same cycle; order is preserved.
REQ-035 SHALL cover this case: FIFOEmpty asserted after 1 word -> one read only; OutValid drops after the pop; no spurious capture.
REQ-036 SHALL cover this case: macro defined, 65537 pops -> WordCount = 1.
